// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles the program-load, sequencing handshake and status signals of the
// instruction fetch unit.
//   master : upstream host / control-unit side (drives start, program load, done)
//   slave  : the fetch unit itself (drives run, instruction, pc, status)
// Signals:
//   start        1         begin execution at address 0 (single-cycle pulse)
//   prog_len     ADDR_W+1  number of instructions to run, sampled on start
//   prog_we      1         program memory write enable
//   prog_addr    ADDR_W    program memory write address
//   prog_data    16        program memory write data
//   done         1         control unit completion strobe
//   run          1         run enable to the control unit
//   instruction  16        instruction register
//   pc           ADDR_W    address of the current instruction
//   instr_count  ADDR_W+1  instructions retired since the last start
//   busy/halted/error      status flags
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 4
) ();
  logic              start;
  logic [ADDR_W:0]   prog_len;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [15:0]       prog_data;
  logic              done;
  logic              run;
  logic [15:0]       instruction;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W:0]   instr_count;
  logic              busy;
  logic              halted;
  logic              error;

  modport master (
    output start, prog_len, prog_we, prog_addr, prog_data, done,
    input  run, instruction, pc, instr_count, busy, halted, error
  );

  modport slave (
    input  start, prog_len, prog_we, prog_addr, prog_data, done,
    output run, instruction, pc, instr_count, busy, halted, error
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Program sequencer in front of the processor control unit. Holds a loadable
// program memory and a program counter, fetches one 16-bit instruction at a
// time and holds `run` high until the control unit reports `done`. Stops at the
// programmed length (HALT) or when the watchdog expires (ERROR).
// Ports:
//   clk    system clock, all state updates on posedge
//   reset  synchronous, active-high reset (program memory is not reset)
//   bus    instr_fetch_unit_if.slave: program load, start/done handshake,
//          run/instruction/pc/instr_count and busy/halted/error status
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.slave   bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_HALT  = 3'd3;
  localparam logic [2:0] ST_ERROR = 3'd4;

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  // Last EXEC cycle the watchdog tolerates without done.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic [15:0]       mem_r [DEPTH];
  logic [ADDR_W:0]   len_r;
  logic [WD_W-1:0]   wd_r;
  logic [ADDR_W-1:0] pc_r;
  logic [15:0]       instr_r;
  logic [ADDR_W:0]   count_r;
  logic              run_r;
  logic              busy_r;
  logic              halted_r;
  logic              error_r;
  logic [ADDR_W:0]   clip_len_s;
  logic              last_s;
  logic              idle_like_s;
  logic              wr_ok_s;

  // States in which the program may be loaded and a start accepted.
  assign idle_like_s = (state_r == ST_IDLE) || (state_r == ST_HALT) ||
                       (state_r == ST_ERROR);
  // Current instruction is the final one of the programmed length.
  assign last_s  = (({1'b0, pc_r} + (ADDR_W + 1)'(1)) == len_r);
  assign wr_ok_s = bus.prog_we && idle_like_s &&
                   ({1'b0, bus.prog_addr} < DEPTH_L);

  // Clip the requested program length to the memory depth.
  always_comb begin
    clip_len_s = bus.prog_len;
    if (bus.prog_len > DEPTH_L) begin
      clip_len_s = DEPTH_L;
    end else begin
      clip_len_s = bus.prog_len;
    end
  end

  // Next-state decode; done takes priority over the watchdog.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_HALT, ST_ERROR: begin
        if (bus.start) begin
          if (clip_len_s != (ADDR_W + 1)'(0)) begin
            state_nxt_s = ST_FETCH;
          end else begin
            state_nxt_s = ST_HALT;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_FETCH: begin
        state_nxt_s = ST_EXEC;
      end
      ST_EXEC: begin
        if (bus.done) begin
          if (last_s) begin
            state_nxt_s = ST_HALT;
          end else begin
            state_nxt_s = ST_FETCH;
          end
        end else if (wd_r == WD_LAST) begin
          state_nxt_s = ST_ERROR;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Program memory write port; no reset so a loaded program survives reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[bus.prog_addr] <= bus.prog_data;
    end
  end

  // Sequencer state, datapath registers and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      len_r    <= '0;
      wd_r     <= '0;
      pc_r     <= '0;
      instr_r  <= 16'h0000;
      count_r  <= '0;
      run_r    <= 1'b0;
      busy_r   <= 1'b0;
      halted_r <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      // Flags are registered from the next state so they track state_r exactly.
      run_r    <= (state_nxt_s == ST_EXEC);
      busy_r   <= (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_EXEC);
      halted_r <= (state_nxt_s == ST_HALT);
      error_r  <= (state_nxt_s == ST_ERROR);
      case (state_r)
        ST_IDLE, ST_HALT, ST_ERROR: begin
          if (bus.start) begin
            pc_r    <= '0;
            count_r <= '0;
            len_r   <= clip_len_s;
          end
        end
        ST_FETCH: begin
          instr_r <= mem_r[pc_r];
          wd_r    <= '0;
        end
        ST_EXEC: begin
          wd_r <= wd_r + WD_W'(1);
          if (bus.done) begin
            count_r <= count_r + (ADDR_W + 1)'(1);
            if (!last_s) begin
              pc_r <= pc_r + ADDR_W'(1);
            end
          end
        end
        default: begin
          wd_r <= '0;
        end
      endcase
    end
  end

  assign bus.run         = run_r;
  assign bus.instruction = instr_r;
  assign bus.pc          = pc_r;
  assign bus.instr_count = count_r;
  assign bus.busy        = busy_r;
  assign bus.halted      = halted_r;
  assign bus.error       = error_r;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Program sequencer directly upstream of the processor control unit.
- Holds a small loadable program memory and a program counter, presents one 16-bit instruction at a time, and drives `run` to the control unit.
- Holds `run` high until the control unit's `done`, then advances to the next instruction.
- Stops at the programmed length, or on a watchdog timeout.

Parameters:
- DEPTH, 16: number of 16-bit instruction words in program memory.
- ADDR_W, 4: address width; must satisfy 2^ADDR_W >= DEPTH.
- TIMEOUT, 8: maximum cycles in EXEC without `done` before error.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins execution at address 0.
- prog_len  input  ADDR_W+1  number of instructions to run; sampled when `start` is accepted.
- prog_we  input  1  program memory write enable.
- prog_addr  input  ADDR_W  program memory write address.
- prog_data  input  16  program memory write data.
- done  input  1  control unit completion strobe (high in its STORE state).
- run  output  1  run enable to the control unit.
- instruction  output  16  instruction register, fed to the control unit.
- pc  output  ADDR_W  address of the current instruction.
- instr_count  output  ADDR_W+1  instructions retired since the last start.
- busy  output  1  high in FETCH or EXEC.
- halted  output  1  high in HALT.
- error  output  1  high in ERROR (watchdog expired).

Behaviour:
- Reset:
  - State goes to IDLE.
  - `run`, `instruction`, `pc`, `instr_count`, `busy`, `halted`, `error` all go to 0.
  - Latched length is cleared; watchdog counter is cleared.
  - Program memory contents are NOT reset.
  - Reset mid-program aborts immediately. The control unit shares this reset, so both restart cleanly.
- States: IDLE, FETCH, EXEC, HALT, ERROR.
- IDLE, HALT, ERROR:
  - `prog_we` writes `prog_data` to `mem[prog_addr]` at the clock edge.
  - Addresses >= DEPTH are ignored.
  - `start` is accepted: `pc` <= 0, `instr_count` <= 0, length <= min(prog_len, DEPTH), `error` cleared.
  - Next state is FETCH if the clipped length > 0, else HALT.
- FETCH (1 cycle):
  - `instruction` <= `mem[pc]`; next state EXEC; `run` = 0.
  - `instruction` is stable from here until the next FETCH.
- EXEC:
  - `run` = 1, decoded combinationally from state.
  - Watchdog counter starts at 0 on entry and increments each EXEC cycle.
  - On a clock edge with `done` = 1: `instr_count` += 1.
    - If `pc` + 1 == length: next state HALT, and `pc` holds the last address.
    - Else `pc` <= `pc` + 1 and next state FETCH.
  - If the watchdog reaches TIMEOUT with no `done`: next state ERROR, `run` drops, `pc` holds the faulting address.
  - `done` and timeout in the same cycle: `done` wins.
- `run` is deasserted for exactly one cycle (FETCH) between instructions, so the control unit holds its initial state while `instruction` changes.
- Nominal throughput: 5 cycles per instruction (1 FETCH + 4 EXEC).
- `done` outside EXEC is ignored.
- `start` while `busy` is ignored.
- `prog_we` while `busy` is ignored; memory is unchanged.
- HALT and ERROR persist until `start` or `reset`.
- `busy` = FETCH | EXEC. `halted` = (state == HALT). `error` = (state == ERROR).
- `pc` wraps never: length <= DEPTH bounds it.

Test Plan:
- Load `mem[0]` = 16'h2800 and `mem[1]` = 16'h4425, `prog_len` = 2, pulse `start`, with the bench returning `done` on the 4th EXEC cycle.
  - Cycle 1: FETCH; `instruction` = 16'h2800 from cycle 2.
  - `run` is high in cycles 2-5, low in cycle 6.
  - `instruction` = 16'h4425 from cycle 7.
  - `halted` = 1 from cycle 11, `instr_count` = 2, `pc` = 1.
- `prog_len` = 0, `start` -> no FETCH, `run` never high, `halted` = 1 the next cycle, `instr_count` = 0.
- TIMEOUT = 8 and `done` held low -> `run` high for exactly 8 cycles, then `error` = 1, `run` = 0, `pc` = 0.
  - A subsequent `start` clears `error` and re-runs from address 0.
- `prog_len` = 20 with DEPTH = 16 -> exactly 16 instructions retire, `halted` = 1, `instr_count` = 16.
- `reset` asserted during the 2nd EXEC cycle of instruction 3 -> the next cycle shows all outputs 0 and state IDLE.
  - Memory is retained: re-`start` fetches the original `mem[0]`.
- Mid-run `prog_we` to address 1 with 16'hFFFF and a mid-run `start` pulse -> both are ignored.
  - `instruction` for pc 1 equals the original value, and `pc` is not reset.
